palette_out: RTL and testbench

- Final video output stage. Sits directly downstream of the sprite/tile compositor and consumes its 4-bit colour index.
- Resolves the index through a 16-entry 12-bit RGB palette that the CPU can write.
- Applies blanking, delays the sync signals to match the pixel pipeline, and drives the VGA pins.
- Also provides a vblank flag and a frame counter that CPU software polls.

---
 rtl/palette_out_if.sv | 30 +++
 rtl/palette_out.sv | 139 +++++++++++++
 tb/tb_palette_out.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/palette_out_if.sv
// Pixel/sync/palette-write bundle between the compositor side and the palette output stage.
interface palette_out_if;
   logic [9:0]  video_hpos_i;
   logic [9:0]  video_vpos_i;
   logic        video_hsync_i;
   logic        video_vsync_i;
   logic [3:0]  color_i;
   logic        pal_wr_en_i;
   logic [3:0]  pal_wr_idx_i;
   logic [11:0] pal_wr_data_i;
   logic [3:0]  vga_r_o;
   logic [3:0]  vga_g_o;
   logic [3:0]  vga_b_o;
   logic        vga_hsync_o;
   logic        vga_vsync_o;
   logic        vblank_o;
   logic [15:0] frame_cnt_o;

   modport slave (
      input  video_hpos_i, video_vpos_i, video_hsync_i, video_vsync_i, color_i,
      input  pal_wr_en_i, pal_wr_idx_i, pal_wr_data_i,
      output vga_r_o, vga_g_o, vga_b_o, vga_hsync_o, vga_vsync_o, vblank_o, frame_cnt_o
   );

   modport master (
      output video_hpos_i, video_vpos_i, video_hsync_i, video_vsync_i, color_i,
      output pal_wr_en_i, pal_wr_idx_i, pal_wr_data_i,
      input  vga_r_o, vga_g_o, vga_b_o, vga_hsync_o, vga_vsync_o, vblank_o, frame_cnt_o
   );
endinterface

// File: rtl/palette_out.sv
// Final video stage: 16x12 palette lookup, blanking, 2-cycle sync alignment, vblank and frame count.
// Optional PALETTE_SHADOW_EN: CPU writes are buffered in a shadow palette and committed at vsync.
module palette_out #(
   parameter int unsigned H_ACTIVE        = 640,
   parameter int unsigned V_ACTIVE        = 480,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   palette_out_if.slave bus
);
   localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

   typedef logic [11:0] rgb_t;

   typedef struct packed {
      logic       valid;
      logic       active;
      logic       hsync;
      logic       vsync;
      logic [3:0] color;
   } s0_t;

   typedef struct packed {
      logic       valid;
      logic       active;
      logic       hsync;
      logic       vsync;
      rgb_t       rgb;
   } s1_t;

   function automatic rgb_t grey(input logic [3:0] i);
      return {i, i, i};
   endfunction

   rgb_t        pal_q [16];
   rgb_t        pal_d [16];
   s0_t         s0_q, s0_d;
   s1_t         s1_q, s1_d;
   logic        vs_prev_q;
   logic        vblank_q, vblank_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        vs_rise;
   logic        pix_on;

   // Edge register resets high so a vsync already asserted at release is not counted.
   assign vs_rise = bus.video_vsync_i & ~vs_prev_q;

`ifdef PALETTE_SHADOW_EN
   rgb_t        shadow_q [16];
   rgb_t        shadow_d [16];
   logic [15:0] pend_q, pend_d;

   // A write in the commit cycle must survive the pending clear, so it is applied last.
   always_comb begin
      shadow_d = shadow_q;
      pend_d   = pend_q;
      pal_d    = pal_q;
      if (vs_rise) begin
         for (int i = 0; i < 16; i++) begin
            if (pend_q[i]) pal_d[i] = shadow_q[i];
         end
         pend_d = '0;
      end
      if (bus.pal_wr_en_i) begin
         shadow_d[bus.pal_wr_idx_i] = bus.pal_wr_data_i;
         pend_d[bus.pal_wr_idx_i]   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) shadow_q[i] <= grey(4'(i));
         pend_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
      end
   end
`else
   // NOTE: combinational blocks assign every output a default first, so no latch can be inferred.
   always_comb begin
      pal_d = pal_q;
      if (bus.pal_wr_en_i) pal_d[bus.pal_wr_idx_i] = bus.pal_wr_data_i;
   end
`endif

   // NOTE: the palette is built from flops so it can reset to the grey ramp; a RAM could not.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) pal_q[i] <= grey(4'(i));
      end else begin
         pal_q <= pal_d;
      end
   end

   always_comb begin
      s0_d.valid  = 1'b1;
      s0_d.active = (bus.video_hpos_i < H_LIM) && (bus.video_vpos_i < V_LIM);
      s0_d.hsync  = bus.video_hsync_i;
      s0_d.vsync  = bus.video_vsync_i;
      s0_d.color  = bus.color_i;

      s1_d.valid  = s0_q.valid;
      s1_d.active = s0_q.active;
      s1_d.hsync  = s0_q.hsync;
      s1_d.vsync  = s0_q.vsync;
      s1_d.rgb    = pal_q[s0_q.color];

      vblank_d    = (bus.video_vpos_i >= V_LIM);
      frame_cnt_d = vs_rise ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s0_q        <= '0;
         s1_q        <= '0;
         vs_prev_q   <= 1'b1;
         vblank_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         s0_q        <= s0_d;
         s1_q        <= s1_d;
         vs_prev_q   <= bus.video_vsync_i;
         vblank_q    <= vblank_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pix_on          = s1_q.valid & s1_q.active;
   assign bus.vga_r_o     = pix_on ? s1_q.rgb[11:8] : 4'h0;
   assign bus.vga_g_o     = pix_on ? s1_q.rgb[7:4]  : 4'h0;
   assign bus.vga_b_o     = pix_on ? s1_q.rgb[3:0]  : 4'h0;
   assign bus.vga_hsync_o = (s1_q.valid & s1_q.hsync) ^ SYNC_ACTIVE_LOW;
   assign bus.vga_vsync_o = (s1_q.valid & s1_q.vsync) ^ SYNC_ACTIVE_LOW;
   assign bus.vblank_o    = vblank_q;
   assign bus.frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_palette_out.sv
// Directed bench for palette_out: inputs change on the falling edge, outputs are checked there too.
// Shadow-palette cases are selected by PALETTE_SHADOW_EN, matching the RTL build.
module tb_palette_out;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_bad    = 0;
   int   exp_frames = 0;

   palette_out_if bus ();

   palette_out dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [31:0] rgb();
      return {20'h0, bus.vga_r_o, bus.vga_g_o, bus.vga_b_o};
   endfunction

   task automatic pal_write(input logic [3:0] idx, input logic [11:0] data);
      bus.pal_wr_en_i   = 1'b1;
      bus.pal_wr_idx_i  = idx;
      bus.pal_wr_data_i = data;
      tick();
      bus.pal_wr_en_i   = 1'b0;
   endtask

   initial begin
      rst_n             = 1'b0;
      bus.video_hpos_i  = 10'd10;
      bus.video_vpos_i  = 10'd10;
      bus.video_hsync_i = 1'b0;
      bus.video_vsync_i = 1'b1;
      bus.color_i       = 4'd5;
      bus.pal_wr_en_i   = 1'b0;
      bus.pal_wr_idx_i  = 4'd0;
      bus.pal_wr_data_i = 12'h000;
      repeat (3) tick();

      check("rst_rgb", rgb(), 32'h000);
      check("rst_hsync", 32'(bus.vga_hsync_o), 32'd1);
      check("rst_vsync", 32'(bus.vga_vsync_o), 32'd1);
      check("rst_vblank", 32'(bus.vblank_o), 32'd0);
      check("rst_frame", 32'(bus.frame_cnt_o), 32'd0);

      // vsync already high at release must not count as a frame
      rst_n = 1'b1;
      repeat (3) tick();
      check("first_vs_nocount", 32'(bus.frame_cnt_o), 32'd0);
      check("grey5", rgb(), 32'h555);
      bus.video_vsync_i = 1'b0;
      repeat (3) tick();

      // sync delay and polarity, plus frame count on the vsync rise
      bus.video_hsync_i = 1'b1;
      bus.video_vsync_i = 1'b1;
      tick();
      exp_frames++;
      check("hs_delay1", 32'(bus.vga_hsync_o), 32'd1);
      check("frame_inc", 32'(bus.frame_cnt_o), 32'(exp_frames));
      tick();
      check("hs_delay2", 32'(bus.vga_hsync_o), 32'd0);
      check("vs_delay2", 32'(bus.vga_vsync_o), 32'd0);
      bus.video_hsync_i = 1'b0;
      bus.video_vsync_i = 1'b0;
      tick();
      check("hs_hold", 32'(bus.vga_hsync_o), 32'd0);
      tick();
      check("hs_release", 32'(bus.vga_hsync_o), 32'd1);
      check("vs_release", 32'(bus.vga_vsync_o), 32'd1);

`ifndef PALETTE_SHADOW_EN
      pal_write(4'd3, 12'hF80);
      bus.color_i = 4'd3;
      repeat (2) tick();
      check("pal_wr_f80", rgb(), 32'hF80);
      // write and read of entry 3 in the same cycle: old value first
      pal_write(4'd3, 12'h0AB);
      check("rd_first_old", rgb(), 32'hF80);
      tick();
      check("rd_first_new", rgb(), 32'h0AB);

      // back-to-back writes, including background entry 0
      bus.pal_wr_en_i   = 1'b1;
      bus.pal_wr_idx_i  = 4'd4;
      bus.pal_wr_data_i = 12'h123;
      tick();
      bus.pal_wr_idx_i  = 4'd5;
      bus.pal_wr_data_i = 12'h456;
      tick();
      bus.pal_wr_idx_i  = 4'd0;
      bus.pal_wr_data_i = 12'h00F;
      tick();
      bus.pal_wr_en_i   = 1'b0;
      bus.color_i = 4'd4;
      tick();
      bus.color_i = 4'd5;
      tick();
      check("b2b_idx4", rgb(), 32'h123);
      bus.color_i = 4'd0;
      tick();
      check("b2b_idx5", rgb(), 32'h456);
      tick();
      check("b2b_idx0", rgb(), 32'h00F);
`endif

      // blanking boundaries and vblank
      bus.color_i      = 4'd7;
      bus.video_hpos_i = 10'd640;
      repeat (2) tick();
      check("blank_h640", rgb(), 32'h000);
      bus.video_hpos_i = 10'd639;
      repeat (2) tick();
      check("active_h639", rgb(), 32'h777);
      bus.video_hpos_i = 10'd10;
      bus.video_vpos_i = 10'd480;
      tick();
      check("vblank_set", 32'(bus.vblank_o), 32'd1);
      tick();
      check("blank_v480", rgb(), 32'h000);
      bus.video_vpos_i = 10'd479;
      tick();
      check("vblank_clr", 32'(bus.vblank_o), 32'd0);
      tick();
      check("active_v479", rgb(), 32'h777);
      bus.video_vpos_i = 10'd10;

      // long vsync pulse counts once
      bus.video_vsync_i = 1'b1;
      repeat (100) tick();
      bus.video_vsync_i = 1'b0;
      tick();
      exp_frames++;
      check("vs_long_once", 32'(bus.frame_cnt_o), 32'(exp_frames));

      // wrap from 0xFFFF
      force dut.frame_cnt_q = 16'hFFFF;
      repeat (2) tick();
      release dut.frame_cnt_q;
      tick();
      check("frame_preload", 32'(bus.frame_cnt_o), 32'h0000FFFF);
      bus.video_vsync_i = 1'b1;
      tick();
      check("frame_wrap", 32'(bus.frame_cnt_o), 32'h00000000);
      bus.video_vsync_i = 1'b0;
      tick();
      bus.video_vsync_i = 1'b1;
      tick();
      check("frame_post_wrap", 32'(bus.frame_cnt_o), 32'd1);
      bus.video_vsync_i = 1'b0;
      exp_frames = 1;
      tick();

`ifdef PALETTE_SHADOW_EN
      bus.color_i = 4'd1;
      repeat (2) tick();
      check("sh_grey1", rgb(), 32'h111);
      pal_write(4'd1, 12'h0F0);
      repeat (4) tick();
      check("sh_hold_midframe", rgb(), 32'h111);
      bus.video_vsync_i = 1'b1;
      tick();
      exp_frames++;
      check("sh_commit_edge", rgb(), 32'h111);
      tick();
      check("sh_committed", rgb(), 32'h0F0);
      bus.video_vsync_i = 1'b0;
      tick();

      // entry 2 pending; entry 1 written in the commit cycle itself
      pal_write(4'd2, 12'h00F);
      tick();
      bus.video_vsync_i = 1'b1;
      pal_write(4'd1, 12'hABC);
      exp_frames++;
      bus.video_vsync_i = 1'b0;
      repeat (2) tick();
      check("sh_commit_wr_deferred", rgb(), 32'h0F0);
      bus.color_i = 4'd2;
      repeat (2) tick();
      check("sh_pending_committed", rgb(), 32'h00F);
      bus.color_i = 4'd1;
      bus.video_vsync_i = 1'b1;
      tick();
      exp_frames++;
      bus.video_vsync_i = 1'b0;
      repeat (2) tick();
      check("sh_next_vsync", rgb(), 32'hABC);
      check("sh_frames", 32'(bus.frame_cnt_o), 32'(exp_frames));
`endif

      // reset mid-line, then refill
      bus.color_i       = 4'd9;
      bus.video_hsync_i = 1'b1;
      repeat (2) tick();
      check("pre_rst_rgb", rgb(), 32'h999);
      check("pre_rst_hs", 32'(bus.vga_hsync_o), 32'd0);
      rst_n = 1'b0;
      tick();
      check("mid_rst_rgb", rgb(), 32'h000);
      check("mid_rst_hs", 32'(bus.vga_hsync_o), 32'd1);
      check("mid_rst_frame", 32'(bus.frame_cnt_o), 32'd0);
      bus.video_hsync_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("refill_gap", rgb(), 32'h000);
      tick();
      check("refill_first", rgb(), 32'h999);
      bus.color_i = 4'd3;
      repeat (2) tick();
      check("pal_rst_grey3", rgb(), 32'h333);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
